// File: rtl/bka8.sv
// bka8: 8-bit unsigned adder built on a Brent-Kung parallel-prefix carry tree.
// The sum and carry-out are purely combinational; a registered copy of both
// is also provided, cleared asynchronously by an active-low reset.

module bka8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] s,
    output logic       cout,
    output logic [7:0] s_r,
    output logic       cout_r
);

    // Bit-level generate and propagate terms.
    logic [7:0] g;
    logic [7:0] p;

    // Up-sweep level 1 group terms.
    // (1:0) only ever feeds a gray cell, so its propagate is never needed.
    logic g_1_0;
    logic g_3_2, p_3_2;
    logic g_5_4, p_5_4;
    logic g_7_6, p_7_6;

    // Up-sweep level 2 group terms.
    logic g_3_0;
    logic g_7_4, p_7_4;

    // Up-sweep level 3 group term.
    logic g_7_0;

    // Down-sweep level 1 group term.
    logic g_5_0;

    // Down-sweep level 2 group terms.
    logic g_2_0;
    logic g_4_0;
    logic g_6_0;

    // Carry into each bit position; carry[0] is the implicit zero carry-in.
    logic [8:0] carry;

    assign g = a & b;
    assign p = a ^ b;

    // Level 1: pairwise groups. Black cells where the group propagate is
    // still needed further up the tree, gray cell for the group anchored at 0.
    assign g_1_0 = g[1] | (p[1] & g[0]);
    assign g_3_2 = g[3] | (p[3] & g[2]);
    assign p_3_2 = p[3] & p[2];
    assign g_5_4 = g[5] | (p[5] & g[4]);
    assign p_5_4 = p[5] & p[4];
    assign g_7_6 = g[7] | (p[7] & g[6]);
    assign p_7_6 = p[7] & p[6];

    // Level 2: four-bit groups.
    assign g_3_0 = g_3_2 | (p_3_2 & g_1_0);
    assign g_7_4 = g_7_6 | (p_7_6 & g_5_4);
    assign p_7_4 = p_7_6 & p_5_4;

    // Level 3: full-width group, which is the carry-out.
    assign g_7_0 = g_7_4 | (p_7_4 & g_3_0);

    // Down-sweep level 1: fill in the six-bit prefix.
    assign g_5_0 = g_5_4 | (p_5_4 & g_3_0);

    // Down-sweep level 2: fill in the remaining odd-length prefixes.
    assign g_2_0 = g[2] | (p[2] & g_1_0);
    assign g_4_0 = g[4] | (p[4] & g_3_0);
    assign g_6_0 = g[6] | (p[6] & g_5_0);

    // Carry into bit i+1 is the group generate over bits i..0.
    assign carry = {g_7_0, g_6_0, g_5_0, g_4_0, g_3_0, g_2_0, g_1_0, g[0], 1'b0};

    assign s    = p ^ carry[7:0];
    assign cout = carry[8];

    // Registered copy of the sum, cleared immediately when reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_r    <= 8'h00;
            cout_r <= 1'b0;
        end else begin
            s_r    <= s;
            cout_r <= cout;
        end
    end

endmodule

// File: tb/tb_bka8.sv
// tb_bka8: randomized and directed bench for bka8. Registered results flow
// through a scoreboard queue checked by an independent monitor; the
// combinational path is checked directly, including an exhaustive sweep.

module tb_bka8;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       cout;
    logic [7:0] s_r;
    logic       cout_r;

    int compared;
    int mismatched;

    // Expected {cout_r, s_r} for each issued operand pair.
    logic [8:0] expect_q[$];
    logic       issued;

    bka8 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .s      (s),
        .cout   (cout),
        .s_r    (s_r),
        .cout_r (cout_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the 9-bit unsigned sum of the operands.
    function automatic logic [8:0] ref_sum(input logic [7:0] x, input logic [7:0] y);
        int total;
        total = int'(x) + int'(y);
        return total[8:0];
    endfunction

    task automatic compare(input string name, input logic [8:0] got, input logic [8:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d (0x%h) expected %0d (0x%h) at a=%0d b=%0d t=%0t",
                     name, got, got, want, want, a, b, $time);
        end
    endtask

    // Monitor: after each rising edge where an operand pair was presented,
    // pop the expected registered result and compare it to s_r/cout_r.
    initial begin
        logic       was_issued;
        logic [8:0] want;
        forever begin
            @(posedge clk);
            was_issued = issued;
            #1;
            if (was_issued) begin
                if (expect_q.size() == 0) begin
                    compare("scoreboard_underflow", 9'h1, 9'h0);
                end else begin
                    want = expect_q.pop_front();
                    compare("registered", {cout_r, s_r}, want);
                end
            end
        end
    end

    // Main stimulus sequence.
    initial begin
        logic [7:0] dir_a [8];
        logic [7:0] dir_b [8];
        logic [8:0] dir_e [8];
        int         sweep_bad;

        dir_a = '{8'd218, 8'd173, 8'd72,  8'd13,  8'd62,  8'd106, 8'd255, 8'd255};
        dir_b = '{8'd9,   8'd138, 8'd235, 8'd125, 8'd186, 8'd89,  8'd1,   8'd255};
        dir_e = '{{1'b0, 8'd227}, {1'b1, 8'd55},  {1'b1, 8'd51},  {1'b0, 8'd138},
                  {1'b0, 8'd248}, {1'b0, 8'd195}, {1'b1, 8'd0},   {1'b1, 8'd254}};

        compared   = 0;
        mismatched = 0;
        issued     = 1'b0;
        rst_n      = 1'b0;
        a          = 8'd0;
        b          = 8'd0;

        // Reset state and zero-operand boundary.
        #3;
        compare("reset_s_r", {cout_r, s_r}, 9'h000);
        compare("zero_sum", {cout, s}, 9'h000);

        // Combinational path works during reset and without any clock reliance.
        a = 8'd218;
        b = 8'd9;
        #10;
        compare("comb_in_reset", {cout, s}, {1'b0, 8'd227});
        compare("reset_holds", {cout_r, s_r}, 9'h000);

        // Reset released between edges; directed combinational vectors.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = dir_a[i];
            b = dir_b[i];
            #1;
            compare($sformatf("directed_%0d", i), {cout, s}, dir_e[i]);
        end

        // Registered path: one clocked load, then reset dropped mid-cycle.
        @(negedge clk);
        a = 8'd102;
        b = 8'd142;
        expect_q.push_back({1'b0, 8'd244});
        issued = 1'b1;
        @(posedge clk);
        #2;
        issued = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        compare("async_clear", {cout_r, s_r}, 9'h000);
        compare("comb_after_clear", {cout, s}, {1'b0, 8'd244});

        // Held in reset across clock edges with non-zero operands.
        a = 8'd200;
        b = 8'd100;
        repeat (2) @(posedge clk);
        #1;
        compare("reset_hold_clocked", {cout_r, s_r}, 9'h000);

        // Release and run random traffic through the registered path.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            expect_q.push_back(ref_sum(a, b));
            issued = 1'b1;
            #1;
            compare("random_comb", {cout, s}, ref_sum(a, b));
            @(negedge clk);
        end
        issued = 1'b0;
        repeat (2) @(negedge clk);
        compare("scoreboard_drained", 9'(expect_q.size()), 9'd0);

        // Exhaustive combinational sweep over every operand pair.
        sweep_bad = 0;
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 256; j++) begin
                a = 8'(i);
                b = 8'(j);
                #1;
                if ({cout, s} !== ref_sum(a, b)) begin
                    sweep_bad++;
                    if (sweep_bad <= 8)
                        $display("[TB] sweep miss a=%0d b=%0d got %0d", a, b, {cout, s});
                end
            end
        end
        compare("exhaustive_misses", 9'(sweep_bad), 9'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got no completion, expected finish before limit");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/bka8.md
BKA8 -- requirements
Module: bka8

Interface
REQ-001 Parameters: none; operand width fixed at 8 bits.
REQ-002 clk  input  1  rising-edge clock for the registered outputs only.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 a  input  8  addend A, unsigned.
REQ-005 b  input  8  addend B, unsigned.
REQ-006 s  output  8  combinational sum bits [7:0] of a+b.
REQ-007 cout  output  1  combinational carry-out (bit 8) of a+b.
REQ-008 s_r  output  8  registered copy of s.
REQ-009 cout_r  output  1  registered copy of cout.
REQ-010 Design has one clock (clk); reset is asynchronous and active-low (rst_n).

Function
REQ-011 {cout,s} SHALL equal a+b (9-bit unsigned result) for all 65536 input pairs; no carry-in (c0 = 0).
REQ-012 s and cout SHALL be purely combinational from a, b: zero-cycle latency, independent of clk and rst_n.
REQ-013 Bit-level terms SHALL be g[i] = a[i]&b[i] and p[i] = a[i]^b[i], for i = 0..7.
REQ-014 Carries SHALL come from a Brent-Kung parallel-prefix tree built from black cells (G = Gh | Ph&Gl, P = Ph&Pl) and gray cells (G only).
REQ-015 Up-sweep level 1 SHALL form groups (1:0), (3:2), (5:4), (7:6).
REQ-016 Up-sweep level 2 SHALL form groups (3:0) and (7:4).
REQ-017 Up-sweep level 3 SHALL form group (7:0).
REQ-018 Down-sweep level 1 SHALL form group (5:0) from (5:4) and (3:0).
REQ-019 Down-sweep level 2 SHALL form groups (2:0), (4:0), (6:0).
REQ-020 Carry c[i+1] SHALL equal G(i:0); s[i] = p[i] ^ c[i] with c[0] = 0; cout = G(7:0).
REQ-021 Prefix depth SHALL be at most 2*log2(8)-1 = 5 cell levels.
REQ-022 No behavioural '+' operator SHALL be used for the sum datapath.
REQ-023 On each rising clk edge with rst_n high, s_r <= s and cout_r <= cout (1-cycle latency).
REQ-024 Overflow SHALL wrap: s holds the low 8 bits and cout flags the carry; no saturation.
REQ-025 X/Z-free inputs SHALL always yield X-free outputs; there are no internal state or enables.

Reset
REQ-026 rst_n low SHALL immediately (asynchronously) force s_r = 8'h00 and cout_r = 0.
REQ-027 While rst_n is low, s_r/cout_r SHALL hold 0 regardless of clk.
REQ-028 After rst_n deasserts, the first rising clk edge SHALL load s_r/cout_r from s/cout.
REQ-029 Reset SHALL NOT affect s or cout; the combinational sum remains valid during reset.
REQ-030 Reset asserted mid-operation SHALL clear the registered outputs without waiting for a clock edge.

Verification
REQ-031 a=218, b=9 -> s=227, cout=0, within 10 ns, no clock needed.
REQ-032 a=173, b=138 -> s=55, cout=1; a=72, b=235 -> s=51, cout=1.
REQ-033 a=13,b=125 -> s=138,cout=0; a=62,b=186 -> s=248,cout=0; a=106,b=89 -> s=195,cout=0.
REQ-034 Boundaries: a=255,b=1 -> s=0,cout=1; a=255,b=255 -> s=254,cout=1; a=0,b=0 -> s=0,cout=0.
REQ-035 Registered path: apply a=102, b=142, clock once -> s_r=244, cout_r=0; then drop rst_n between edges -> s_r=0, cout_r=0 immediately, while s stays 244.
REQ-036 Exhaustive sweep: all 65536 (a,b) pairs, compare {cout,s} to a+b -> zero mismatches.
